// File: rtl/fixed_to_fp32.sv
// Pipelined signed fixed-point to IEEE-754 single-precision converter.
// Four stages (magnitude, leading-one, normalise/round, pack) with valid/ready on both sides.
module fixed_to_fp32 #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned FRAC_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [IN_WIDTH-1:0] in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_data_o,
  output logic                busy_o
);

  logic stall;
  logic accept;

  // Stage 1: sign and magnitude
  logic                s1_valid_q;
  logic                s1_sign_d, s1_sign_q;
  logic [IN_WIDTH-1:0] s1_abs_d, s1_abs_q;

  // Stage 2: leading-one position and zero flag
  logic                s2_valid_q;
  logic                s2_sign_q;
  logic                s2_zero_d, s2_zero_q;
  logic [4:0]          s2_pos_d, s2_pos_q;
  logic [IN_WIDTH-1:0] s2_abs_q;

  // Stage 3: normalised, rounded mantissa
  logic                s3_valid_q;
  logic                s3_sign_q;
  logic                s3_zero_q;
  logic [4:0]          s3_pos_q;
  logic                s3_carry_d, s3_carry_q;
  logic [22:0]         s3_mant_d, s3_mant_q;
  logic [62:0]         s3_shifted;
  logic                s3_guard;
  logic                s3_sticky;
  logic                s3_round_up;

  // Stage 4: packed output
  logic                s4_valid_q;
  logic [7:0]          s4_exp;
  logic [31:0]         s4_data_d, s4_data_q;

  assign stall      = s4_valid_q & ~out_ready_i;
  assign in_ready_o = ~reset & ~stall;
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    s1_sign_d = in_data_i[IN_WIDTH-1];
    s1_abs_d  = s1_sign_d ? -in_data_i : in_data_i;
  end

  always_comb begin
    s2_zero_d = (s1_abs_q == '0);
    s2_pos_d  = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (s1_abs_q[i]) s2_pos_d = 5'(i);
    end
  end

  // Shift so the leading one lands just above bit 62 and drops off; what remains is
  // the 23-bit fraction followed by the guard bit and the sticky field.
  always_comb begin
    s3_shifted  = 63'(s2_abs_q) << (6'd63 - {1'b0, s2_pos_q});
    s3_guard    = s3_shifted[39];
    s3_sticky   = |s3_shifted[38:0];
    s3_round_up = s3_guard & (s3_sticky | s3_shifted[40]);
    s3_mant_d   = s3_shifted[62:40] + 23'(s3_round_up);
    s3_carry_d  = s3_round_up & (&s3_shifted[62:40]);
  end

  // Exponent always lies in 1..254, so modulo-256 arithmetic gives the exact field.
  always_comb begin
    s4_exp    = 8'd127 + 8'(s3_pos_q) - 8'(FRAC_BITS) + 8'(s3_carry_q);
    s4_data_d = '0;
    if (s3_valid_q && !s3_zero_q) s4_data_d = {s3_sign_q, s4_exp, s3_mant_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s4_valid_q <= 1'b0;
      s4_data_q  <= '0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      s4_valid_q <= s3_valid_q;
      s4_data_q  <= s4_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sign_q  <= s1_sign_d;
      s1_abs_q   <= s1_abs_d;
      s2_sign_q  <= s1_sign_q;
      s2_abs_q   <= s1_abs_q;
      s2_zero_q  <= s2_zero_d;
      s2_pos_q   <= s2_pos_d;
      s3_sign_q  <= s2_sign_q;
      s3_zero_q  <= s2_zero_q;
      s3_pos_q   <= s2_pos_q;
      s3_carry_q <= s3_carry_d;
      s3_mant_q  <= s3_mant_d;
    end
  end

  assign out_valid_o = s4_valid_q;
  assign out_data_o  = s4_data_q;
  assign busy_o      = s1_valid_q | s2_valid_q | s3_valid_q | s4_valid_q;

endmodule

// File: tb/tb_fixed_to_fp32.sv
// Directed and random checks for fixed_to_fp32 (16/8 instance plus a 32/0 rounding instance).
module tb_fixed_to_fp32;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  logic        in_valid_w;
  logic        in_ready_w;
  logic [31:0] in_data_w;
  logic        out_valid_w;
  logic        out_ready_w;
  logic [31:0] out_data_w;
  logic        busy_w;

  int checks;
  int failures;

  fixed_to_fp32 #(.IN_WIDTH(16), .FRAC_BITS(8)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .busy_o      (busy)
  );

  fixed_to_fp32 #(.IN_WIDTH(32), .FRAC_BITS(0)) u_dut_wide (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_w),
    .in_ready_o  (in_ready_w),
    .in_data_i   (in_data_w),
    .out_valid_o (out_valid_w),
    .out_ready_i (out_ready_w),
    .out_data_o  (out_data_w),
    .busy_o      (busy_w)
  );

  always #5 clk = ~clk;

  task automatic next_window();
    @(posedge clk);
    #1;
  endtask

  // Real-valued reference: scale to a real, normalise into [1,2), read off the fraction.
  function automatic logic [31:0] ref_fp(input logic [15:0] d);
    real a;
    int  e;
    logic s;
    if (d == 16'h0000) return 32'h0;
    a = $itor($signed(d)) / 256.0;
    s = (a < 0.0);
    if (s) a = -a;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    return {s, 8'(127 + e), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0100;
    repeat (2) next_window();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state valid=%b data=%08h busy=%b in_ready=%b expected 0/0/0/0",
               out_valid, out_data, busy, in_ready);
    end
    next_window();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release in_ready=%b expected 1", in_ready);
    end
    next_window();
  endtask

  task automatic test_basic();
    logic [15:0] vin [6];
    logic [31:0] vexp[6];
    vin[0] = 16'h0100; vexp[0] = 32'h3F800000;
    vin[1] = 16'hFF00; vexp[1] = 32'hBF800000;
    vin[2] = 16'h8000; vexp[2] = 32'hC3000000;
    vin[3] = 16'h7FFF; vexp[3] = 32'h42FFFE00;
    vin[4] = 16'h0001; vexp[4] = 32'h3B800000;
    vin[5] = 16'h0000; vexp[5] = 32'h00000000;
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      for (int w = 0; w < 6; w++) begin
        in_valid = (w == 0);
        in_data  = vin[v];
        @(negedge clk);
        if (w == 0) begin
          checks++;
          if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_in_ready[%0d] got=%b expected 1", v, in_ready);
          end
        end else if (w == 4) begin
          checks++;
          if (out_valid !== 1'b1 || out_data !== vexp[v]) begin
            failures++;
            $display("FAIL basic_result[%0d] in=%04h valid=%b data=%08h expected %08h",
                     v, vin[v], out_valid, out_data, vexp[v]);
          end
        end else begin
          checks++;
          if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL basic_bubble[%0d] w=%0d valid=%b data=%08h expected 0/00000000",
                     v, w, out_valid, out_data);
          end
          if (w == 1) begin
            checks++;
            if (busy !== 1'b1) begin
              failures++;
              $display("FAIL basic_busy[%0d] got=%b expected 1", v, busy);
            end
          end
        end
        next_window();
      end
    end
  endtask

  task automatic test_throughput();
    logic [15:0] vin [3];
    logic [31:0] vexp[3];
    vin[0] = 16'h0100; vexp[0] = 32'h3F800000;
    vin[1] = 16'h0200; vexp[1] = 32'h40000000;
    vin[2] = 16'h0300; vexp[2] = 32'h40400000;
    for (int w = 0; w < 8; w++) begin
      in_valid = (w < 3);
      in_data  = (w < 3) ? vin[w] : 16'h0;
      @(negedge clk);
      checks++;
      if (w >= 4 && w <= 6) begin
        if (out_valid !== 1'b1 || out_data !== vexp[w-4]) begin
          failures++;
          $display("FAIL throughput w=%0d valid=%b data=%08h expected %08h",
                   w, out_valid, out_data, vexp[w-4]);
        end
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL throughput_idle w=%0d valid=%b expected 0", w, out_valid);
      end
      next_window();
    end
  endtask

  task automatic test_rounding();
    logic [31:0] vin [3];
    logic [31:0] vexp[3];
    vin[0] = 32'h01000001; vexp[0] = 32'h4B800000;
    vin[1] = 32'h01000003; vexp[1] = 32'h4B800002;
    vin[2] = 32'h7FFFFFFF; vexp[2] = 32'h4F000000;
    out_ready_w = 1'b1;
    for (int w = 0; w < 8; w++) begin
      in_valid_w = (w < 3);
      in_data_w  = (w < 3) ? vin[w] : 32'h0;
      @(negedge clk);
      checks++;
      if (w >= 4 && w <= 6) begin
        if (out_valid_w !== 1'b1 || out_data_w !== vexp[w-4]) begin
          failures++;
          $display("FAIL rounding in=%08h valid=%b data=%08h expected %08h",
                   vin[w-4], out_valid_w, out_data_w, vexp[w-4]);
        end
      end else if (out_valid_w !== 1'b0) begin
        failures++;
        $display("FAIL rounding_idle w=%0d valid=%b expected 0", w, out_valid_w);
      end
      next_window();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] vin [8];
    logic [31:0] vexp[8];
    int sent;
    int recv;
    int c;
    vin[0] = 16'h0100; vexp[0] = 32'h3F800000;
    vin[1] = 16'h0200; vexp[1] = 32'h40000000;
    vin[2] = 16'hFD00; vexp[2] = 32'hC0400000;
    vin[3] = 16'h0400; vexp[3] = 32'h40800000;
    vin[4] = 16'h0500; vexp[4] = 32'h40A00000;
    vin[5] = 16'hFA00; vexp[5] = 32'hC0C00000;
    vin[6] = 16'h0080; vexp[6] = 32'h3F000000;
    vin[7] = 16'h0800; vexp[7] = 32'h41000000;
    sent = 0;
    recv = 0;
    c    = 0;
    while (recv < 8 && c < 60) begin
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? vin[sent] : 16'h0;
      out_ready = !(c >= 4 && c < 9);
      @(negedge clk);
      if (c >= 4 && c < 9) begin
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== vexp[0]) begin
          failures++;
          $display("FAIL stall c=%0d valid=%b in_ready=%b data=%08h expected 1/0/%08h",
                   c, out_valid, in_ready, out_data, vexp[0]);
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== vexp[recv]) begin
          failures++;
          $display("FAIL bp_order[%0d] data=%08h expected %08h", recv, out_data, vexp[recv]);
        end
        recv++;
      end
      next_window();
      c++;
    end
    checks++;
    if (recv != 8) begin
      failures++;
      $display("FAIL bp_count received=%0d expected 8", recv);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL bp_extra w=%0d valid=%b data=%08h expected no output", w, out_valid, out_data);
      end
      next_window();
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    for (int w = 0; w < 10; w++) begin
      reset    = (w == 3);
      in_valid = (w < 3) || (w == 4);
      in_data  = (w < 3) ? 16'(16'h0700 + 16'(w) * 16'h0100) : 16'h0500;
      @(negedge clk);
      checks++;
      if (w == 3) begin
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL midreset_in_ready got=%b expected 0", in_ready);
        end
      end else if (w == 4) begin
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
          failures++;
          $display("FAIL midreset_flush valid=%b busy=%b in_ready=%b expected 0/0/1",
                   out_valid, busy, in_ready);
        end
      end else if (w == 8) begin
        if (out_valid !== 1'b1 || out_data !== 32'h40A00000) begin
          failures++;
          $display("FAIL midreset_first valid=%b data=%08h expected 40a00000", out_valid, out_data);
        end
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset_ghost w=%0d valid=%b data=%08h expected no output",
                 w, out_valid, out_data);
      end
      next_window();
    end
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_q[$];
    logic [31:0] e;
    int sent;
    int recv;
    int c;
    sent = 0;
    recv = 0;
    c    = 0;
    while (recv < 10000 && c < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_fp(in_data));
        sent++;
      end
      if (!out_valid && out_data !== 32'h0) begin
        checks++;
        failures++;
        $display("FAIL rand_bubble c=%0d data=%08h expected 00000000", c, out_data);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_spurious c=%0d data=%08h expected no output", c, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            failures++;
            $display("FAIL rand[%0d] data=%08h expected %08h", recv, out_data, e);
          end
        end
        recv++;
      end
      next_window();
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (recv != 10000 || exp_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rand_drain received=%0d pending=%0d busy=%b expected 10000/0/0",
               recv, exp_q.size(), busy);
    end
    next_window();
  endtask

  initial begin
    clk         = 1'b0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 16'h0;
    out_ready   = 1'b1;
    in_valid_w  = 1'b0;
    in_data_w   = 32'h0;
    out_ready_w = 1'b1;
    checks      = 0;
    failures    = 0;
    #1;
    test_reset();
    test_basic();
    test_throughput();
    test_rounding();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
